// File: rtl/vcve2_pkg.sv
// Shared types and limits for the OBI memory responder.
package vcve2_pkg;

   localparam int unsigned ObiMaxLatency     = 8;
   localparam int unsigned ObiMaxOutstanding = 8;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } obi_resp_t;

endpackage

// File: rtl/vcve2_obi_mem_responder_if.sv
// OBI-style req/gnt/rvalid bus between an initiator (master) and the memory responder (slave).
interface vcve2_obi_mem_responder_if;

   logic        req;
   logic        gnt;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, we, be, addr, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output gnt, rvalid, rdata, err
   );

endinterface

// File: rtl/vcve2_obi_resp_pipe.sv
// Fixed-depth shift delay line for response valid + payload, cleared asynchronously.
module vcve2_obi_resp_pipe
   import vcve2_pkg::*;
#(
   parameter int unsigned Depth = 1
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      in_valid_i,
   input  obi_resp_t in_resp_i,
   output logic      out_valid_o,
   output obi_resp_t out_resp_o
);

   logic      valid_q [Depth];
   obi_resp_t resp_q  [Depth];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < Depth; i++) begin
            valid_q[i] <= 1'b0;
            resp_q[i]  <= '0;
         end
      end else begin
         valid_q[0] <= in_valid_i;
         // Idle slots carry zeros so the output payload is 0 whenever valid is low.
         resp_q[0]  <= in_valid_i ? in_resp_i : '0;
         for (int i = 1; i < Depth; i++) begin
            valid_q[i] <= valid_q[i-1];
            resp_q[i]  <= resp_q[i-1];
         end
      end
   end

   assign out_valid_o = valid_q[Depth-1];
   assign out_resp_o  = resp_q[Depth-1];

endmodule

// File: rtl/vcve2_obi_mem_responder.sv
// OBI memory responder: grants requests, accesses a word array at the grant edge and
// returns each response a fixed latency later, in grant order.
module vcve2_obi_mem_responder
   import vcve2_pkg::*;
#(
   parameter int unsigned MemWords       = 1024,
   parameter logic [31:0] BaseAddr       = 32'h0000_0000,
   parameter int unsigned RespLatency    = 1,
   parameter int unsigned MaxOutstanding = 2,
   parameter string       MemInitFile    = ""
) (
   input logic                         clk_i,
   input logic                         rst_i,
   input logic                         stall_i,
   vcve2_obi_mem_responder_if.slave    bus
);

   localparam int unsigned IdxW     = (MemWords > 1) ? $clog2(MemWords) : 1;
   localparam logic [32:0] MemBytes = 33'(MemWords) << 2;

   if (RespLatency < 1 || RespLatency > ObiMaxLatency) begin : gen_bad_latency
      $error("RespLatency out of range 1..8");
   end
   if (MaxOutstanding < 1 || MaxOutstanding > ObiMaxOutstanding) begin : gen_bad_outstanding
      $error("MaxOutstanding out of range 1..8");
   end
   if (BaseAddr[1:0] != 2'b00 || MemWords < 1) begin : gen_bad_geometry
      $error("BaseAddr must be word aligned and MemWords nonzero");
   end

   logic [31:0] mem [MemWords];

   logic [32:0]     offset;
   logic            in_range;
   logic [IdxW-1:0] idx;
   logic            xfer;
   logic            rvalid;
   obi_resp_t       resp_in;
   obi_resp_t       resp_out;
   logic [3:0]      count_q, count_d;

   // 33-bit subtraction: addresses below BaseAddr go negative instead of wrapping.
   assign offset   = {1'b0, bus.addr} - {1'b0, BaseAddr};
   assign in_range = ~offset[32] & (offset < MemBytes);
   assign idx      = offset[IdxW+1:2];

   // A response leaving this cycle frees its slot, so the grant may reuse it immediately.
   assign bus.gnt = bus.req & ~stall_i & ~rst_i &
                    ((count_q < 4'(MaxOutstanding)) | rvalid);
   assign xfer    = bus.req & bus.gnt;

   always_ff @(posedge clk_i) begin
      if (xfer && bus.we && in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.be[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      resp_in.rdata = '0;
      resp_in.err   = ~in_range;
      if (in_range && !bus.we) resp_in.rdata = mem[idx];
   end

   vcve2_obi_resp_pipe #(
      .Depth (RespLatency)
   ) u_resp_pipe (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (xfer),
      .in_resp_i   (resp_in),
      .out_valid_o (rvalid),
      .out_resp_o  (resp_out)
   );

   assign bus.rvalid = rvalid;
   assign bus.rdata  = resp_out.rdata;
   assign bus.err    = resp_out.err;

   always_comb begin
      count_d = count_q;
      case ({xfer, rvalid})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) count_q <= '0;
      else       count_q <= count_d;
   end

`ifndef SYNTHESIS
   req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (bus.req && !bus.gnt) |=> $stable({bus.we, bus.be, bus.addr, bus.wdata}));
   cnt_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      count_q <= 4'(MaxOutstanding));
   cnt_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(rvalid && count_q == 4'd0));
`endif

endmodule

// File: tb/tb_vcve2_obi_mem_responder.sv
// Bench for vcve2_obi_mem_responder: two instances (latency 1 and latency 3), table-driven
// transfers with an in-order response scoreboard, plus stall, throttle and reset sequences.
module tb_vcve2_obi_mem_responder;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        req   [2];
   logic        we    [2];
   logic [3:0]  be    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic        stall [2];
   logic        gnt   [2];
   logic        rvalid[2];
   logic [31:0] rdata [2];
   logic        err   [2];

   int   checks = 0;
   int   passed = 0;
   int   cyc    = 0;
   exp_t q0[$];
   exp_t q1[$];
   bit   glog[$];

   vec_t tbl_a [18];
   vec_t tbl_b [11];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vcve2_obi_mem_responder_if if_a ();
   vcve2_obi_mem_responder_if if_b ();

   assign if_a.req = req[0];   assign if_b.req = req[1];
   assign if_a.we = we[0];     assign if_b.we = we[1];
   assign if_a.be = be[0];     assign if_b.be = be[1];
   assign if_a.addr = addr[0]; assign if_b.addr = addr[1];
   assign if_a.wdata = wdata[0]; assign if_b.wdata = wdata[1];
   assign gnt[0] = if_a.gnt;       assign gnt[1] = if_b.gnt;
   assign rvalid[0] = if_a.rvalid; assign rvalid[1] = if_b.rvalid;
   assign rdata[0] = if_a.rdata;   assign rdata[1] = if_b.rdata;
   assign err[0] = if_a.err;       assign err[1] = if_b.err;

   vcve2_obi_mem_responder #(
      .MemWords       (256),
      .BaseAddr       (32'h0000_0000),
      .RespLatency    (1),
      .MaxOutstanding (2),
      .MemInitFile    ("")
   ) dut_a (
      .clk_i   (clk),
      .rst_i   (rst),
      .stall_i (stall[0]),
      .bus     (if_a)
   );

   vcve2_obi_mem_responder #(
      .MemWords       (64),
      .BaseAddr       (32'h0000_8000),
      .RespLatency    (3),
      .MaxOutstanding (2),
      .MemInitFile    ("")
   ) dut_b (
      .clk_i   (clk),
      .rst_i   (rst),
      .stall_i (stall[1]),
      .bus     (if_b)
   );

   function automatic int lat(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic void check(input string name, input logic [95:0] act,
                                 input logic [95:0] exp_v);
      checks++;
      if (act === exp_v) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp_v);
   endfunction

   function automatic vec_t mk(input logic w, input logic [3:0] b, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] er,
                               input logic ee);
      vec_t v;
      v.we = w; v.be = b; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
      return v;
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   task automatic push_exp(input int d, input vec_t v);
      exp_t e;
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      e.due   = cyc + lat(d);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Response monitor: every rvalid must match the oldest expectation, in its due cycle.
   task automatic mon(input int d);
      exp_t e;
      if (rst) begin
         check($sformatf("reset_outputs[%0d]", d), {rvalid[d], rdata[d], err[d]}, '0);
      end else if (rvalid[d]) begin
         if (qsize(d) == 0) begin
            check($sformatf("spurious_rvalid[%0d]", d), rvalid[d], 1'b0);
         end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("resp[%0d]", d), {32'(cyc), rdata[d], 31'b0, err[d]},
                  {32'(e.due), e.rdata, 31'b0, e.err});
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   // Present one request at a negedge and hold it until granted (bounded).
   task automatic issue(input int d, input vec_t v, output bit ok);
      int n;
      n = 0;
      ok = 1'b0;
      @(negedge clk);
      req[d] = 1'b1; we[d] = v.we; be[d] = v.be; addr[d] = v.addr; wdata[d] = v.wdata;
      #1;
      while (!gnt[d]) begin
         if (d == 1) glog.push_back(1'b0);
         n++;
         if (n > 20) begin
            check($sformatf("grant_timeout[%0d]", d), gnt[d], 1'b1);
            return;
         end
         @(negedge clk);
         #1;
      end
      if (d == 1) glog.push_back(1'b1);
      push_exp(d, v);
      ok = 1'b1;
   endtask

   task automatic idle(input int d);
      @(negedge clk);
      req[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      int n;
      n = 0;
      while (qsize(d) != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (qsize(d) != 0) check($sformatf("drain_timeout[%0d]", d), 32'(qsize(d)), '0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      bit pat [5];
      pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; addr[d] = '0; wdata[d] = '0;
         stall[d] = 1'b0;
      end

      tbl_a[0]  = mk(1, 4'hF, 32'h10,       32'hDEADBEEF, 32'h0,        0);
      tbl_a[1]  = mk(0, 4'hF, 32'h10,       32'h0,        32'hDEADBEEF, 0);
      tbl_a[2]  = mk(1, 4'h5, 32'h10,       32'h11223344, 32'h0,        0);
      tbl_a[3]  = mk(0, 4'h0, 32'h13,       32'h0,        32'hDE22BE44, 0);
      tbl_a[4]  = mk(1, 4'hF, 32'h20,       32'hCAFEF00D, 32'h0,        0);
      tbl_a[5]  = mk(0, 4'hF, 32'h20,       32'h0,        32'hCAFEF00D, 0);
      tbl_a[6]  = mk(1, 4'hF, 32'h24,       32'h12345678, 32'h0,        0);
      tbl_a[7]  = mk(1, 4'h0, 32'h24,       32'hFFFFFFFF, 32'h0,        0);
      tbl_a[8]  = mk(0, 4'hF, 32'h24,       32'h0,        32'h12345678, 0);
      tbl_a[9]  = mk(1, 4'hF, 32'h0,        32'h01020304, 32'h0,        0);
      tbl_a[10] = mk(1, 4'hF, 32'h400,      32'hFFFFFFFF, 32'h0,        1);
      tbl_a[11] = mk(0, 4'hF, 32'h400,      32'h0,        32'h0,        1);
      tbl_a[12] = mk(0, 4'hF, 32'h0,        32'h0,        32'h01020304, 0);
      tbl_a[13] = mk(1, 4'hF, 32'h3FC,      32'hAABBCCDD, 32'h0,        0);
      tbl_a[14] = mk(0, 4'hF, 32'h3FC,      32'h0,        32'hAABBCCDD, 0);
      tbl_a[15] = mk(0, 4'hF, 32'hFFFFFFFC, 32'h0,        32'h0,        1);
      tbl_a[16] = mk(1, 4'h1, 32'h20,       32'h000000EE, 32'h0,        0);
      tbl_a[17] = mk(0, 4'hF, 32'h20,       32'h0,        32'hCAFEF0EE, 0);

      tbl_b[0]  = mk(1, 4'hF, 32'h8000, 32'hA0A0A0A0, 32'h0,        0);
      tbl_b[1]  = mk(1, 4'hF, 32'h8004, 32'hB1B1B1B1, 32'h0,        0);
      tbl_b[2]  = mk(1, 4'hF, 32'h8008, 32'hC2C2C2C2, 32'h0,        0);
      tbl_b[3]  = mk(1, 4'hF, 32'h800C, 32'hD3D3D3D3, 32'h0,        0);
      tbl_b[4]  = mk(1, 4'hF, 32'h80FC, 32'h0F0F0F0F, 32'h0,        0);
      tbl_b[5]  = mk(0, 4'hF, 32'h80FC, 32'h0,        32'h0F0F0F0F, 0);
      tbl_b[6]  = mk(0, 4'hF, 32'h8100, 32'h0,        32'h0,        1);
      tbl_b[7]  = mk(0, 4'hF, 32'h7FFC, 32'h0,        32'h0,        1);
      tbl_b[8]  = mk(1, 4'hF, 32'h7FFC, 32'h55555555, 32'h0,        1);
      tbl_b[9]  = mk(0, 4'hF, 32'h8000, 32'h0,        32'hA0A0A0A0, 0);
      tbl_b[10] = mk(0, 4'hF, 32'h80FC, 32'h0,        32'h0F0F0F0F, 0);

      // Reset: no grant even with a request present.
      @(negedge clk);
      req[0] = 1'b1; addr[0] = 32'h10;
      #1 check("reset_gnt", gnt[0], 1'b0);
      req[0] = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;

      // Latency-1 instance: back-to-back stream from the table.
      for (int i = 0; i < 18; i++) begin
         issue(0, tbl_a[i], ok);
         if (!ok) break;
      end
      idle(0);
      drain(0);

      // Stall holds off the grant; release grants in the same cycle.
      @(negedge clk);
      stall[0] = 1'b1;
      req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h10; wdata[0] = '0;
      for (int i = 0; i < 5; i++) begin
         #1 check("stall_gnt", gnt[0], 1'b0);
         @(negedge clk);
      end
      stall[0] = 1'b0;
      #1 check("unstall_gnt", gnt[0], 1'b1);
      if (gnt[0]) push_exp(0, mk(0, 4'hF, 32'h10, 32'h0, 32'hDE22BE44, 0));
      idle(0);
      drain(0);

      // Latency-3 instance with two outstanding slots.
      for (int i = 0; i < 11; i++) begin
         issue(1, tbl_b[i], ok);
         if (!ok) break;
      end
      idle(1);
      drain(1);

      glog.delete();
      issue(1, mk(0, 4'hF, 32'h8000, 32'h0, 32'hA0A0A0A0, 0), ok);
      issue(1, mk(0, 4'hF, 32'h8004, 32'h0, 32'hB1B1B1B1, 0), ok);
      issue(1, mk(0, 4'hF, 32'h8008, 32'h0, 32'hC2C2C2C2, 0), ok);
      issue(1, mk(0, 4'hF, 32'h800C, 32'h0, 32'hD3D3D3D3, 0), ok);
      idle(1);
      check("gnt_pattern_len", 32'(glog.size()), 32'd5);
      for (int i = 0; i < 5 && i < glog.size(); i++)
         check($sformatf("gnt_pattern[%0d]", i), glog[i], pat[i]);
      drain(1);

      // Reset with two responses in flight: they must never appear.
      issue(1, mk(0, 4'hF, 32'h8000, 32'h0, 32'hA0A0A0A0, 0), ok);
      issue(1, mk(0, 4'hF, 32'h8004, 32'h0, 32'hB1B1B1B1, 0), ok);
      @(negedge clk);
      addr[1] = 32'h8008;
      #2 rst = 1'b1;
      q1.delete();
      #1 check("rst_hold_gnt", gnt[1], 1'b0);
      @(negedge clk);
      #1 check("rst_hold_gnt2", gnt[1], 1'b0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check("post_reset_gnt", gnt[1], 1'b1);
      if (gnt[1]) push_exp(1, mk(0, 4'hF, 32'h8008, 32'h0, 32'hC2C2C2C2, 0));
      idle(1);
      repeat (8) @(negedge clk);
      drain(1);
      drain(0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
